// File: rtl/snake_body_engine.sv
// ---------------------------------------------------------------------------
// snake_body_engine
//
// Owns the snake position state: head coordinate, body segment array,
// length, movement direction and sticky self-collision flag. One game step
// is accepted per move_tick and applied at the next frame_sync, which means
// state only changes during vertical blanking. The body array is streamed to
// the renderer continuously, one entry per clock.
//
// Ports
//   clock_25                in  system clock
//   reset                   in  synchronous, active-high
//   frame_sync              in  1-cycle pulse at start of vertical blanking
//   move_tick               in  1-cycle pulse requesting one game step
//   up/down/left/right      in  direction keys (level)
//   grow                    in  sampled with move_tick: fruit eaten this step
//   snake_head_x/y          out head block coordinate (registered)
//   body_count              out stream index, 0..SNAKE_LENGTH_MAX-2
//   snake_body_x/y          out body[body_count], same cycle as body_count
//   snake_length            out number of valid body entries
//   step_pending            out step accepted, waiting for frame_sync
//   collision               out sticky: head ran into the body
// ---------------------------------------------------------------------------
module snake_body_engine #(
  parameter int SNAKE_LENGTH_BIT = 4,
  parameter int SNAKE_LENGTH_MAX = 16,
  parameter int GRID_W           = 124,
  parameter int GRID_H           = 81,
  parameter int START_X          = 62,
  parameter int START_Y          = 40,
  parameter int INIT_LENGTH      = 3
) (
  input  logic                        clock_25,
  input  logic                        reset,
  input  logic                        frame_sync,
  input  logic                        move_tick,
  input  logic                        up,
  input  logic                        down,
  input  logic                        left,
  input  logic                        right,
  input  logic                        grow,
  output logic [6:0]                  snake_head_x,
  output logic [6:0]                  snake_head_y,
  output logic [SNAKE_LENGTH_BIT-1:0] body_count,
  output logic [6:0]                  snake_body_x,
  output logic [6:0]                  snake_body_y,
  output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
  output logic                        step_pending,
  output logic                        collision
);

  localparam int DEPTH = SNAKE_LENGTH_MAX - 1;
  localparam int LW    = SNAKE_LENGTH_BIT;

  localparam logic [LW-1:0] LAST_IDX  = LW'(SNAKE_LENGTH_MAX - 2);
  localparam logic [LW-1:0] MAX_LEN   = LW'(SNAKE_LENGTH_MAX - 1);
  localparam logic [LW-1:0] INIT_LEN  = LW'(INIT_LENGTH);
  localparam logic [6:0]    X_MAX     = 7'(GRID_W - 1);
  localparam logic [6:0]    Y_MAX     = 7'(GRID_H - 1);
  localparam logic [6:0]    X_START   = 7'(START_X);
  localparam logic [6:0]    Y_START   = 7'(START_Y);

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DEAD = 1'b1
  } state_t;

  // Direction that would undo the given one; such a key press is ignored.
  function automatic dir_t opposite(input dir_t d);
    dir_t o;
    case (d)
      DIR_UP:    o = DIR_DOWN;
      DIR_DOWN:  o = DIR_UP;
      DIR_LEFT:  o = DIR_RIGHT;
      DIR_RIGHT: o = DIR_LEFT;
      default:   o = DIR_LEFT;
    endcase
    return o;
  endfunction

  // Reset x of body entry idx: a horizontal line trailing left of the head;
  // entries beyond the initial length sit on the initial tail.
  function automatic logic [6:0] init_body_x(input int idx);
    int v;
    if (idx < INIT_LENGTH) begin
      v = START_X - 1 - idx;
    end else begin
      v = START_X - INIT_LENGTH;
    end
    return 7'(v);
  endfunction

  // State registers
  state_t          state_q;
  dir_t            dir_q;
  logic [6:0]      head_x_q;
  logic [6:0]      head_y_q;
  logic [6:0]      body_x_q [DEPTH];
  logic [6:0]      body_y_q [DEPTH];
  logic [LW-1:0]   length_q;
  logic [LW-1:0]   body_count_q;
  logic            step_pending_q;
  logic            grow_lat_q;
  logic            collision_q;

  // Combinational next values / decisions
  dir_t            dir_d;
  logic [6:0]      head_x_d;
  logic [6:0]      head_y_d;
  logic            step_apply_s;
  logic            grow_eff_s;
  logic            grow_ok_s;
  logic [LW:0]     hit_limit_s;
  logic            hit_s;

  // Direction register next value: highest-priority held key, unless it reverses.
  always_comb begin
    dir_d = dir_q;
    if (up) begin
      if (opposite(dir_q) != DIR_UP) dir_d = DIR_UP;
      else                           dir_d = dir_q;
    end else if (down) begin
      if (opposite(dir_q) != DIR_DOWN) dir_d = DIR_DOWN;
      else                             dir_d = dir_q;
    end else if (right) begin
      if (opposite(dir_q) != DIR_RIGHT) dir_d = DIR_RIGHT;
      else                              dir_d = dir_q;
    end else if (left) begin
      if (opposite(dir_q) != DIR_LEFT) dir_d = DIR_LEFT;
      else                             dir_d = dir_q;
    end else begin
      dir_d = dir_q;
    end
  end

  // Candidate head one block ahead in the current direction, wrapping at the edges.
  always_comb begin
    head_x_d = head_x_q;
    head_y_d = head_y_q;
    case (dir_q)
      DIR_RIGHT: begin
        if (head_x_q == X_MAX) head_x_d = 7'd0;
        else                   head_x_d = head_x_q + 7'd1;
      end
      DIR_LEFT: begin
        if (head_x_q == 7'd0) head_x_d = X_MAX;
        else                  head_x_d = head_x_q - 7'd1;
      end
      DIR_UP: begin
        if (head_y_q == 7'd0) head_y_d = Y_MAX;
        else                  head_y_d = head_y_q - 7'd1;
      end
      DIR_DOWN: begin
        if (head_y_q == Y_MAX) head_y_d = 7'd0;
        else                   head_y_d = head_y_q + 7'd1;
      end
      default: begin
        head_x_d = head_x_q;
        head_y_d = head_y_q;
      end
    endcase
  end

  // Step decision and self-collision check against the pre-shift body.
  // Without growth the tail vacates its block this step, so it is excluded.
  always_comb begin
    step_apply_s = (state_q == ST_RUN) && (step_pending_q || move_tick) && frame_sync;
    if (step_pending_q) grow_eff_s = grow_lat_q;
    else                grow_eff_s = grow;
    grow_ok_s = grow_eff_s && (length_q < MAX_LEN);
    if (grow_ok_s) hit_limit_s = {1'b0, length_q};
    else           hit_limit_s = {1'b0, length_q} - {{LW{1'b0}}, 1'b1};
    hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((i < int'(hit_limit_s)) &&
          (body_x_q[i] == head_x_d) && (body_y_q[i] == head_y_d)) begin
        hit_s = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Main state machine: stream index, direction, step latch and step apply.
  always_ff @(posedge clock_25) begin
    if (reset) begin
      state_q        <= ST_RUN;
      dir_q          <= DIR_RIGHT;
      head_x_q       <= X_START;
      head_y_q       <= Y_START;
      length_q       <= INIT_LEN;
      body_count_q   <= {LW{1'b0}};
      step_pending_q <= 1'b0;
      grow_lat_q     <= 1'b0;
      collision_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        body_x_q[i] <= init_body_x(i);
        body_y_q[i] <= Y_START;
      end
    end else begin
      // Stream index free-runs in every state.
      if (body_count_q == LAST_IDX) body_count_q <= {LW{1'b0}};
      else                          body_count_q <= body_count_q + {{(LW-1){1'b0}}, 1'b1};

      dir_q <= dir_d;

      case (state_q)
        ST_RUN: begin
          if (step_apply_s) begin
            body_x_q[0] <= head_x_q;
            body_y_q[0] <= head_y_q;
            for (int i = 1; i < DEPTH; i++) begin
              body_x_q[i] <= body_x_q[i-1];
              body_y_q[i] <= body_y_q[i-1];
            end
            head_x_q <= head_x_d;
            head_y_q <= head_y_d;
            if (grow_ok_s) length_q <= length_q + {{(LW-1){1'b0}}, 1'b1};
            step_pending_q <= 1'b0;
            grow_lat_q     <= 1'b0;
            if (hit_s) begin
              collision_q <= 1'b1;
              state_q     <= ST_DEAD;
            end
          end else if (move_tick && !step_pending_q) begin
            // A tick while a step is already pending is dropped so the
            // first grow request stays latched.
            step_pending_q <= 1'b1;
            grow_lat_q     <= grow;
          end
        end
        ST_DEAD: begin
          state_q <= ST_DEAD;
        end
        default: begin
          // Unreachable encoding: park in DEAD until reset.
          state_q     <= ST_DEAD;
          collision_q <= 1'b1;
        end
      endcase
    end
  end

  assign snake_head_x = head_x_q;
  assign snake_head_y = head_y_q;
  assign snake_length = length_q;
  assign body_count   = body_count_q;
  assign step_pending = step_pending_q;
  assign collision    = collision_q;

  // Stream data is read straight from the array so index and data align.
  assign snake_body_x = body_x_q[body_count_q];
  assign snake_body_y = body_y_q[body_count_q];

endmodule

// File: tb/tb_snake_body_engine.sv
module tb_snake_body_engine;

  localparam int W = 124;
  localparam int H = 81;
  localparam int MAXLEN = 15;

  logic       clk = 1'b0;
  logic       reset, frame_sync, move_tick, up, down, left, right, grow;
  logic [6:0] head_x, head_y, body_x, body_y;
  logic [3:0] body_count, snake_length;
  logic       step_pending, collision;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: head, body as a queue of packed points (x*256+y), direction as a vector.
  int m_hx, m_hy, m_dx, m_dy, m_bc;
  int m_body[$];
  bit m_pend, m_glat, m_dead;
  int seen_coll = 0, seen_maxlen = 0, seen_xwrap = 0, seen_ywrap = 0;

  // Random-phase knobs (percent / per-mille)
  int p_tick, p_sync, p_grow, p_key, pm_reset;

  snake_body_engine dut (
    .clock_25(clk), .reset(reset), .frame_sync(frame_sync), .move_tick(move_tick),
    .up(up), .down(down), .left(left), .right(right), .grow(grow),
    .snake_head_x(head_x), .snake_head_y(head_y), .body_count(body_count),
    .snake_body_x(body_x), .snake_body_y(body_y), .snake_length(snake_length),
    .step_pending(step_pending), .collision(collision)
  );

  always #20 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hx = 62; m_hy = 40; m_dx = 1; m_dy = 0; m_bc = 0;
    m_body.delete();
    for (int i = 0; i < 3; i++) m_body.push_back((61 - i) * 256 + 40);
    m_pend = 0; m_glat = 0; m_dead = 0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    int nx, ny, lim, kx, ky;
    bit g, gok, hit, key;
    if (reset) begin
      model_reset();
      return;
    end
    m_bc = (m_bc + 1) % 15;
    if (!m_dead) begin
      if ((m_pend || move_tick) && frame_sync) begin
        g   = m_pend ? m_glat : grow;
        gok = g && (m_body.size() < MAXLEN);
        nx  = (m_hx + m_dx + W) % W;
        ny  = (m_hy + m_dy + H) % H;
        if (m_hx == W - 1 && nx == 0) seen_xwrap++;
        if (m_hy == 0 && ny == H - 1) seen_ywrap++;
        lim = gok ? m_body.size() : m_body.size() - 1;
        hit = 0;
        for (int i = 0; i < lim; i++) if (m_body[i] == nx * 256 + ny) hit = 1;
        m_body.push_front(m_hx * 256 + m_hy);
        if (!gok) void'(m_body.pop_back());
        if (m_body.size() == MAXLEN) seen_maxlen++;
        m_hx = nx; m_hy = ny;
        if (hit) begin m_dead = 1; seen_coll++; end
        m_pend = 0; m_glat = 0;
      end else if (move_tick && !m_pend) begin
        m_pend = 1; m_glat = grow;
      end
    end
    key = 1; kx = 0; ky = 0;
    if (up)         ky = -1;
    else if (down)  ky = 1;
    else if (right) kx = 1;
    else if (left)  kx = -1;
    else            key = 0;
    if (key && !(kx == -m_dx && ky == -m_dy)) begin m_dx = kx; m_dy = ky; end
  endtask

  task automatic check_all();
    check_val("head_x", int'(head_x), m_hx);
    check_val("head_y", int'(head_y), m_hy);
    check_val("length", int'(snake_length), m_body.size());
    check_val("pending", int'(step_pending), int'(m_pend));
    check_val("collision", int'(collision), int'(m_dead));
    check_val("body_count", int'(body_count), m_bc);
    if (m_bc < m_body.size()) begin
      check_val("body_x", int'(body_x), m_body[m_bc] / 256);
      check_val("body_y", int'(body_y), m_body[m_bc] % 256);
    end
  endtask

  // One clock: check outputs, drive new inputs, step the model. k = {up,down,left,right}.
  task automatic cyc(input bit mt, input bit fs, input bit g, input logic [3:0] k, input bit rst);
    @(negedge clk);
    check_all();
    move_tick = mt; frame_sync = fs; grow = g;
    {up, down, left, right} = k; reset = rst;
    model_edge();
  endtask

  task automatic run_random(input int n, input int key_mode, input logic [3:0] hold_k);
    logic [3:0] k;
    for (int c = 0; c < n; c++) begin
      if (key_mode == 0)      k = 4'b0000;
      else if (key_mode == 1) k = hold_k;
      else                    k = ($urandom_range(99, 0) < p_key) ? 4'($urandom_range(15, 1)) : 4'b0000;
      cyc($urandom_range(99, 0) < p_tick, $urandom_range(99, 0) < p_sync,
          $urandom_range(99, 0) < p_grow, k, $urandom_range(999, 0) < pm_reset);
    end
  endtask

  initial begin
    reset = 1'b1; frame_sync = 1'b0; move_tick = 1'b0; grow = 1'b0;
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state against fixed values, then 20 idle clocks of streaming.
    @(negedge clk);
    check_val("rst_head_x", int'(head_x), 62);
    check_val("rst_head_y", int'(head_y), 40);
    check_val("rst_length", int'(snake_length), 3);
    check_val("rst_count", int'(body_count), 0);
    check_val("rst_body0_x", int'(body_x), 61);
    for (int c = 0; c < 20; c++) cyc(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);

    // Tick, then frame_sync five clocks later.
    cyc(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    for (int c = 0; c < 4; c++) cyc(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    check_val("step_head_x", int'(head_x), 63);

    // Straight run with constant grow: reaches max length and wraps x.
    p_tick = 40; p_sync = 40; p_grow = 100; p_key = 0; pm_reset = 0;
    run_random(900, 0, 4'b0000);
    check_val("maxlen_hold", int'(snake_length), 15);

    // Hold up: wraps y; then hold down while moving up (ignored).
    cyc(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    p_grow = 20;
    run_random(500, 1, 4'b1000);
    run_random(60, 1, 4'b0100);
    // up+left together while moving right.
    cyc(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 4'b1010, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    check_val("upleft_head_y", int'(head_y), 39);

    // U-turn into own body at length 5.
    cyc(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 4'b0000, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 4'b0000, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 4'b1000, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 4'b0010, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 4'b0100, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    for (int c = 0; c < 6; c++) cyc(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    check_val("uturn_coll", int'(collision), 1);
    check_val("dead_head_x", int'(head_x), 63);
    check_val("dead_head_y", int'(head_y), 40);
    cyc(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    check_val("reset_clears_coll", int'(collision), 0);

    // Free random play with occasional resets (including mid-step).
    p_tick = 30; p_sync = 25; p_grow = 35; p_key = 60; pm_reset = 4;
    run_random(7000, 2, 4'b0000);
    cyc(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);

    check_val("saw_collision", int'(seen_coll > 0), 1);
    check_val("saw_maxlen", int'(seen_maxlen > 0), 1);
    check_val("saw_xwrap", int'(seen_xwrap > 0), 1);
    check_val("saw_ywrap", int'(seen_ywrap > 0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
